datapath_test_1: RTL

Datapath stage driven by the sequencing controller. It consumes the controller's `sel1`, `sel2`, `mux1` and `done` strobes, loads two operands from a shared input bus and adds them. It presents the result to the downstream consumer through a valid/ready handshake. It sits directly downstream of the controller FSM and is the only consumer of its select outputs.

---
 rtl/datapath_test_1_if.sv | 25 ++
 rtl/datapath_test_1.sv | 69 ++++++
 2 files changed

// File: rtl/datapath_test_1_if.sv
// rtl/datapath_test_1_if.sv - strobe, operand and result-handshake bundle between controller, datapath and consumer
interface datapath_test_1_if #(
  parameter int W = 8
);
  logic         sel1;
  logic         sel2;
  logic         mux1;
  logic         done;
  logic [W-1:0] data_in;
  logic         out_ready;
  logic         out_valid;
  logic [W:0]   out_data;
  logic         ovf;
  logic [7:0]   op_count;

  modport master (
    output sel1, sel2, mux1, done, data_in, out_ready,
    input  out_valid, out_data, ovf, op_count
  );

  modport slave (
    input  sel1, sel2, mux1, done, data_in, out_ready,
    output out_valid, out_data, ovf, op_count
  );
endinterface

// File: rtl/datapath_test_1.sv
// rtl/datapath_test_1.sv - two-operand adder stage publishing results on the rising edge of done
// Optional DATAPATH_SAT_EN: saturate the sum to all-ones instead of keeping the carry.
module datapath_test_1 #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  datapath_test_1_if.slave    bus
);

  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W:0]   sum;
  logic [W:0]   sum_next;
  logic [W:0]   raw_add;
  logic         done_q;
  logic [W:0]   out_data_q;
  logic         out_valid_q;
  logic         ovf_q;
  logic [7:0]   op_count_q;
  logic         publish;

  assign raw_add = {1'b0, reg_a} + {1'b0, reg_b};
  assign publish = bus.done & ~done_q;

  always_comb begin
    sum_next = raw_add;
`ifdef DATAPATH_SAT_EN
    if (raw_add[W]) sum_next = {1'b0, {W{1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a       <= '0;
      reg_b       <= '0;
      sum         <= '0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (bus.sel1) reg_a <= bus.data_in;
      if (bus.sel2) reg_b <= bus.data_in;
      if (bus.mux1) sum   <= sum_next;
      done_q <= bus.done;

      // A publish may land in the same edge that drains the previous result.
      if (publish) begin
        op_count_q <= op_count_q + 8'd1;
        if (!out_valid_q || bus.out_ready) begin
          out_data_q  <= sum;
          out_valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.op_count  = op_count_q;

endmodule
